// File: rtl/arcade_video_front_pkg.sv
// Shared definitions for the arcade video front end: legal packed-colour
// widths and the packed-to-8-bit-per-channel colour expansion.
package arcade_video_front_pkg;

    localparam int unsigned DW_2R2G2B = 6;
    localparam int unsigned DW_3R3G2B = 8;
    localparam int unsigned DW_3R3G3B = 9;
    localparam int unsigned DW_4R4G4B = 12;
    localparam int unsigned DW_8R8G8B = 24;

    function automatic logic dw_legal(input int unsigned dw);
        return (dw == DW_2R2G2B) || (dw == DW_3R3G2B) || (dw == DW_3R3G3B) ||
               (dw == DW_4R4G4B) || (dw == DW_8R8G8B);
    endfunction

    // rgb holds the packed pixel right-aligned; returns {R, G, B}.
    function automatic logic [23:0] expand_rgb(input logic [23:0] rgb, input int unsigned dw);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        case (dw)
            DW_2R2G2B: begin
                r = {4{rgb[5:4]}};
                g = {4{rgb[3:2]}};
                b = {4{rgb[1:0]}};
            end
            DW_3R3G2B: begin
                r = {rgb[7:5], rgb[7:5], rgb[7:6]};
                g = {rgb[4:2], rgb[4:2], rgb[4:3]};
                b = {4{rgb[1:0]}};
            end
            DW_3R3G3B: begin
                r = {rgb[8:6], rgb[8:6], rgb[8:7]};
                g = {rgb[5:3], rgb[5:3], rgb[5:4]};
                b = {rgb[2:0], rgb[2:0], rgb[2:1]};
            end
            DW_4R4G4B: begin
                r = {rgb[11:8], rgb[11:8]};
                g = {rgb[7:4], rgb[7:4]};
                b = {rgb[3:0], rgb[3:0]};
            end
            default: begin
                r = rgb[23:16];
                g = rgb[15:8];
                b = rgb[7:0];
            end
        endcase
        // Narrow sources carry at most four significant bits per channel.
        if (dw != DW_8R8G8B) begin
            r = {r[7:4], r[7:4]};
            g = {g[7:4], g[7:4]};
            b = {b[7:4], b[7:4]};
        end
        return {r, g, b};
    endfunction

endpackage

// File: rtl/arcade_video_front_if.sv
// Raw core video in, VGA-style pixel stream and scaler controls out.
// CE_PIXEL is a one-cycle strobe marking valid VGA_* outputs; there is no
// ready/back-pressure, the sink must accept every strobe.
interface arcade_video_front_if #(parameter int DW = 8);

    logic          ce_pix;
    logic [DW-1:0] RGB_in;
    logic          HBlank;
    logic          VBlank;
    logic          HSync;
    logic          VSync;
    logic [2:0]    fx;
    logic          forced_scandoubler;

    logic          CE_PIXEL;
    logic [7:0]    VGA_R;
    logic [7:0]    VGA_G;
    logic [7:0]    VGA_B;
    logic          VGA_HS;
    logic          VGA_VS;
    logic          VGA_DE;
    logic [1:0]    VGA_SL;
    logic          SCANDOUBLER;

    modport slave (
        input  ce_pix, RGB_in, HBlank, VBlank, HSync, VSync, fx, forced_scandoubler,
        output CE_PIXEL, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, VGA_SL, SCANDOUBLER
    );

    modport master (
        output ce_pix, RGB_in, HBlank, VBlank, HSync, VSync, fx, forced_scandoubler,
        input  CE_PIXEL, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, VGA_SL, SCANDOUBLER
    );

endinterface

// File: rtl/arcade_video_front_sync_fix.sv
// Sync polarity normaliser: measures high and low times of the sync and
// inverts it when the high time is the longer one.
module sync_fix #(
    parameter int CNT_W = 16
) (
    input  logic clk_video,
    input  logic rst,
    input  logic sync_in,
    output logic sync_out
);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] r_neg;
    logic             r_pol;

    always_ff @(posedge clk_video or posedge rst) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_cnt <= '0;
            r_pos <= '0;
            r_neg <= '0;
            r_pol <= 1'b0;
        end else begin
            r_s1 <= sync_in;
            r_s2 <= r_s1;
            if (r_s1 != r_s2) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_s2 && !r_s1) begin
                r_pos <= r_cnt;
            end
            if (!r_s2 && r_s1) begin
                r_neg <= r_cnt;
            end
            r_pol <= (r_pos > r_neg);
        end
    end

    assign sync_out = sync_in ^ r_pol;

endmodule

// File: rtl/arcade_video_front.sv
// Arcade video front end: sync normalisation, pixel capture on ce_pix rise,
// colour expansion and blank-gated VGA-style output registers.
module arcade_video_front
    import arcade_video_front_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk_video,
    input  logic                  rst,
    arcade_video_front_if.slave   vid
);

    logic          w_hs_fix;
    logic          w_vs_fix;
    logic          w_ce_rise;
    logic          w_de;
    logic [23:0]   w_exp;

    logic          r_old_ce;
    logic          r_ce;
    logic          r_hs;
    logic          r_vs;
    logic          r_hbl;
    logic          r_vbl;
    logic [DW-1:0] r_rgb_fix;

    sync_fix #(.CNT_W(CNT_W)) u_hs_fix (
        .clk_video (clk_video),
        .rst       (rst),
        .sync_in   (vid.HSync),
        .sync_out  (w_hs_fix)
    );

    sync_fix #(.CNT_W(CNT_W)) u_vs_fix (
        .clk_video (clk_video),
        .rst       (rst),
        .sync_in   (vid.VSync),
        .sync_out  (w_vs_fix)
    );

    assign w_ce_rise = !r_old_ce && vid.ce_pix;

    // VS moves only on an HS rise and VBL only at the end of HBlank, so
    // vertical timing changes always land on a line boundary.
    always_ff @(posedge clk_video or posedge rst) begin
        if (rst) begin
            r_old_ce  <= 1'b0;
            r_ce      <= 1'b0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_hbl     <= 1'b0;
            r_vbl     <= 1'b0;
            r_rgb_fix <= '0;
        end else begin
            r_old_ce <= vid.ce_pix;
            r_ce     <= 1'b0;
            if (w_ce_rise) begin
                r_ce      <= 1'b1;
                r_hs      <= w_hs_fix;
                r_rgb_fix <= vid.RGB_in;
                r_hbl     <= vid.HBlank;
                if (!r_hs && w_hs_fix) begin
                    r_vs <= w_vs_fix;
                end
                if (r_hbl && !vid.HBlank) begin
                    r_vbl <= vid.VBlank;
                end
            end
        end
    end

    assign w_de  = !(r_hbl || r_vbl);
    assign w_exp = expand_rgb(24'(r_rgb_fix), DW);

    always_ff @(posedge clk_video or posedge rst) begin
        if (rst) begin
            vid.CE_PIXEL <= 1'b0;
            vid.VGA_HS   <= 1'b0;
            vid.VGA_VS   <= 1'b0;
            vid.VGA_DE   <= 1'b0;
            vid.VGA_R    <= 8'd0;
            vid.VGA_G    <= 8'd0;
            vid.VGA_B    <= 8'd0;
        end else begin
            vid.CE_PIXEL <= r_ce;
            if (r_ce) begin
                vid.VGA_HS <= r_hs;
                vid.VGA_VS <= r_vs;
                vid.VGA_DE <= w_de;
                vid.VGA_R  <= w_de ? w_exp[23:16] : 8'd0;
                vid.VGA_G  <= w_de ? w_exp[15:8]  : 8'd0;
                vid.VGA_B  <= w_de ? w_exp[7:0]   : 8'd0;
            end
        end
    end

    assign vid.VGA_SL      = (vid.fx != 3'd0) ? (vid.fx[1:0] - 2'd1) : 2'd0;
    assign vid.SCANDOUBLER = (vid.fx != 3'd0) || vid.forced_scandoubler;

endmodule

// File: tb/tb_arcade_video_front.sv
// Self-checking bench for arcade_video_front (DW=8): pixel scoreboard plus
// directed sync-polarity, strobe, control and reset checks.
module tb_arcade_video_front;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_total = 0;
    int n_bad   = 0;
    bit sb_en   = 1'b1;

    logic [26:0] exp_q[$];

    // bench-side model of capture state
    logic m_hs, m_vs, m_hbl, m_vbl;

    arcade_video_front_if #(.DW(8)) vid ();

    arcade_video_front #(.DW(8), .CNT_W(16)) dut (
        .clk_video (clk),
        .rst       (rst),
        .vid       (vid.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp8(input logic [7:0] p);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = p[7:5];
        g = p[4:2];
        b = p[1:0];
        return {r, r[2], r, r[2], g, g[2], g, g[2], b, b, b, b};
    endfunction

    task automatic model_reset();
        m_hs = 1'b0; m_vs = 1'b0; m_hbl = 1'b0; m_vbl = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vid.ce_pix = 1'b0; vid.HSync = 1'b0; vid.VSync = 1'b0;
        vid.HBlank = 1'b0; vid.VBlank = 1'b0; vid.RGB_in = 8'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One ce_pix pulse (high one cycle); syncs are driven raw with pol=0.
    task automatic send_pix(input logic [7:0] rgb, input logic hb, input logic vb,
                            input logic hs, input logic vs);
        logic de;
        @(negedge clk);
        vid.RGB_in = rgb; vid.HBlank = hb; vid.VBlank = vb;
        vid.HSync = hs; vid.VSync = vs; vid.ce_pix = 1'b1;
        if (!m_hs && hs) m_vs = vs;
        if (m_hbl && !hb) m_vbl = vb;
        m_hs = hs;
        m_hbl = hb;
        de = !(m_hbl || m_vbl);
        exp_q.push_back({m_hs, m_vs, de, de ? exp8(rgb) : 24'd0});
        @(negedge clk);
        vid.ce_pix = 1'b0;
    endtask

    // ce_pix held high for 'hold' cycles; strobe expected on the 2nd negedge only.
    task automatic pulse_check(input string tag, input logic [7:0] rgb, input int hold);
        logic de;
        @(negedge clk);
        vid.RGB_in = rgb; vid.HBlank = 1'b0; vid.VBlank = 1'b0; vid.ce_pix = 1'b1;
        if (m_hbl) m_vbl = 1'b0;
        m_hs = 1'b0;
        m_hbl = 1'b0;
        de = !m_vbl;
        exp_q.push_back({m_hs, m_vs, de, de ? exp8(rgb) : 24'd0});
        for (int i = 1; i <= hold + 2; i++) begin
            @(negedge clk);
            if (i == hold) vid.ce_pix = 1'b0;
            check_val(tag, {31'd0, vid.CE_PIXEL}, (i == 2) ? 32'd1 : 32'd0);
        end
        vid.ce_pix = 1'b0;
    endtask

    task automatic hs_shape(input string tag, input logic active_low);
        sb_en = 1'b0;
        vid.HBlank = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                vid.HSync = (c < 8) ^ active_low;
                vid.ce_pix = c[0];
                if (p == 3 && c == 6)  check_val({tag, "_pulse"}, {31'd0, vid.VGA_HS}, 32'd1);
                if (p == 3 && c == 40) check_val({tag, "_idle"},  {31'd0, vid.VGA_HS}, 32'd0);
            end
        end
        vid.ce_pix = 1'b0;
        vid.HBlank = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb_en && !rst && vid.CE_PIXEL) begin
            if (exp_q.size() == 0) begin
                check_val("sb_extra_strobe", 32'd1, 32'd0);
            end else begin
                check_val("sb_pix",
                          {5'd0, vid.VGA_HS, vid.VGA_VS, vid.VGA_DE, vid.VGA_R, vid.VGA_G, vid.VGA_B},
                          {5'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fxv;
        logic [1:0] exp_sl;
        vid.ce_pix = 1'b0; vid.RGB_in = 8'd0; vid.HBlank = 1'b0; vid.VBlank = 1'b0;
        vid.HSync = 1'b0; vid.VSync = 1'b0; vid.fx = 3'd0; vid.forced_scandoubler = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_ce_pixel", {31'd0, vid.CE_PIXEL}, 32'd0);
        check_val("rst_rgb", {8'd0, vid.VGA_R, vid.VGA_G, vid.VGA_B}, 32'd0);
        check_val("rst_syncs_de", {29'd0, vid.VGA_HS, vid.VGA_VS, vid.VGA_DE}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // DW=8 expansion, known constants
        send_pix(8'b101_010_01, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("dw8_strobe", {31'd0, vid.CE_PIXEL}, 32'd1);
        check_val("dw8_r", {24'd0, vid.VGA_R}, 32'hBB);
        check_val("dw8_g", {24'd0, vid.VGA_G}, 32'h44);
        check_val("dw8_b", {24'd0, vid.VGA_B}, 32'h55);
        check_val("dw8_de", {31'd0, vid.VGA_DE}, 32'd1);

        // blanking gates colour
        send_pix(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("hblank_rgb", {8'd0, vid.VGA_R, vid.VGA_G, vid.VGA_B}, 32'd0);
        check_val("hblank_de", {31'd0, vid.VGA_DE}, 32'd0);

        // random pixels, back-to-back
        for (int i = 0; i < 24; i++) begin
            send_pix(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);

        // ce_pix held high for 5 cycles
        pulse_check("ce_hold", 8'h3C, 5);

        // VSync / VBlank alignment to line boundaries
        do_reset();
        repeat (10) @(negedge clk);
        for (int line = 0; line < 4; line++) begin
            for (int px = 0; px < 6; px++) begin
                send_pix(8'($urandom_range(0, 255)), px == 5,
                         (line > 1) || (line == 1 && px >= 2),
                         px == 0, (line > 0) || (px >= 3));
                vid.HSync = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check_val("vs_aligned_end", {31'd0, vid.VGA_VS}, 32'd1);
        check_val("vbl_aligned_end", {31'd0, vid.VGA_DE}, 32'd0);

        // sync polarity normalisation
        do_reset();
        hs_shape("hs_act_low", 1'b1);
        do_reset();
        hs_shape("hs_act_high", 1'b0);
        do_reset();

        // scanline / scandoubler controls
        for (int f = 0; f < 8; f++) begin
            for (int fs = 0; fs < 2; fs++) begin
                fxv = 3'(f);
                vid.fx = fxv;
                vid.forced_scandoubler = fs[0];
                exp_sl = (fxv == 3'd0) ? 2'd0 : 2'((fxv - 3'd1) % 4);
                #1;
                check_val("ctl_sl", {30'd0, vid.VGA_SL}, {30'd0, exp_sl});
                check_val("ctl_sd", {31'd0, vid.SCANDOUBLER}, {31'd0, (fxv != 3'd0) || fs[0]});
            end
        end

        // mid-line reset
        send_pix(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_val("pre_rst_r", {24'd0, vid.VGA_R}, 32'hFF);
        vid.ce_pix = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_rgb", {8'd0, vid.VGA_R, vid.VGA_G, vid.VGA_B}, 32'd0);
        check_val("midrst_ctl", {29'd0, vid.VGA_DE, vid.CE_PIXEL, vid.VGA_HS}, 32'd0);
        model_reset();
        vid.ce_pix = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse_check("post_rst", 8'b110_001_10, 1);

        repeat (4) @(negedge clk);
        check_val("sb_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
